// File: rtl/dk_rom_loader.sv
// dk_rom_loader
// Download-side front end for the Donkey Kong family core. Decodes HPS ioctl
// byte writes into registered ROM region strobes, latches the DIP bank and the
// game-variant byte, keeps byte-count / checksum / address-continuity stats
// for the ROM image, and holds the core in reset during and just after a
// download.
//
// Ports:
//   clk_sys, reset          system clock, async active-high board reset
//   ioctl_download/wr/index/addr/dout   HPS download stream
//   rom_addr, rom_data      registered write address/data for the dprams
//   cpu_rom_we, snd_rom_we, wav_rom_we, dl_wr   one-cycle region strobes
//   dip_bank                8 DIP bytes, byte n at [8n+7:8n]
//   mod_*                   decoded game-variant flags
//   core_reset              reset request to the game core
//   rom_loaded, rom_bytes, rom_sum, addr_err    ROM image stats
//
// state | meaning
// IDLE  | after board reset, no download seen yet; core held in reset
// LOAD  | download active; writes accepted
// HOLD  | download ended; core reset stretched while counter runs down
// READY | image in place; core released
module dk_rom_loader #(
  parameter logic [24:0] CPU_END     = 25'h08000,
  parameter logic [24:0] SND_BASE    = 25'h0E000,
  parameter logic [24:0] SND_END     = 25'h0F000,
  parameter logic [24:0] WAV_BASE    = 25'h0FF00,
  parameter logic [24:0] WAV_END     = 25'h20000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        cpu_rom_we,
  output logic        snd_rom_we,
  output logic        wav_rom_we,
  output logic        dl_wr,
  output logic [63:0] dip_bank,
  output logic        mod_dk,
  output logic        mod_dkjr,
  output logic        mod_dk3,
  output logic        mod_radarscope,
  output logic        mod_pestplace,
  output logic        mod_unknown,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic [24:0] rom_bytes,
  output logic [7:0]  rom_sum,
  output logic        addr_err
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, READY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enter_load, enter_fresh, finish_load;
  logic          dl_idx0_q;
  logic [24:0]   exp_addr_q;
  logic [7:0]    mod_q;

  logic          wr_ok, is_rom, is_mod, is_dip, clear_stats;
  logic [24:0]   bytes_base, exp_base;
  logic [7:0]    sum_base;
  logic          err_base;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enter_load  = 1'b0;
    enter_fresh = 1'b0;
    finish_load = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (ioctl_download) begin
          state_d     = LOAD;
          enter_load  = 1'b1;
          enter_fresh = 1'b1;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_d     = HOLD;
          cnt_d       = HOLD_LOAD;
          finish_load = 1'b1;
        end
      end
      HOLD: begin
        // A re-started download resumes without wiping the stats.
        if (ioctl_download) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_reset = reset | (state_q != READY);

  // ---------------- write decode ----------------
  assign wr_ok  = ioctl_wr & ioctl_download;
  assign is_rom = wr_ok & (ioctl_index == 8'd0);
  assign is_mod = wr_ok & (ioctl_index == 8'd1);
  assign is_dip = wr_ok & (ioctl_index == 8'd254) & (ioctl_addr[24:3] == '0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_addr   <= '0;
      rom_data   <= '0;
      cpu_rom_we <= 1'b0;
      snd_rom_we <= 1'b0;
      wav_rom_we <= 1'b0;
      dl_wr      <= 1'b0;
    end else begin
      cpu_rom_we <= is_rom & (ioctl_addr < CPU_END);
      snd_rom_we <= is_rom & (ioctl_addr >= SND_BASE) & (ioctl_addr < SND_END);
      wav_rom_we <= is_rom & (ioctl_addr >= WAV_BASE) & (ioctl_addr < WAV_END);
      dl_wr      <= is_rom & (ioctl_addr[23:16] == 8'd0);
      if (wr_ok) begin
        rom_addr <= ioctl_addr[15:0];
        rom_data <= ioctl_dout;
      end
    end
  end

  // ---------------- ROM stats ----------------
  // A write on the very edge that enters LOAD must count against the
  // freshly cleared stats, so the update works from the cleared base.
  assign clear_stats = enter_fresh & (ioctl_index == 8'd0);
  assign bytes_base  = clear_stats ? '0   : rom_bytes;
  assign sum_base    = clear_stats ? '0   : rom_sum;
  assign err_base    = clear_stats ? 1'b0 : addr_err;
  assign exp_base    = clear_stats ? '0   : exp_addr_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_bytes  <= '0;
      rom_sum    <= '0;
      addr_err   <= 1'b0;
      exp_addr_q <= '0;
      rom_loaded <= 1'b0;
      dl_idx0_q  <= 1'b0;
    end else begin
      if (enter_load)
        dl_idx0_q <= (ioctl_index == 8'd0);
      if (clear_stats) begin
        rom_bytes  <= '0;
        rom_sum    <= '0;
        addr_err   <= 1'b0;
        exp_addr_q <= '0;
        rom_loaded <= 1'b0;
      end
      if (is_rom) begin
        rom_bytes  <= (bytes_base == '1) ? bytes_base : bytes_base + 25'd1;
        rom_sum    <= sum_base + ioctl_dout;
        addr_err   <= err_base | (ioctl_addr != exp_base);
        exp_addr_q <= ioctl_addr + 25'd1;
      end
      if (finish_load && dl_idx0_q && (rom_bytes != '0) && !addr_err)
        rom_loaded <= 1'b1;
    end
  end

  // ---------------- DIP bank and variant byte ----------------
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip_bank <= '0;
      mod_q    <= '0;
    end else begin
      if (is_dip)
        dip_bank[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      if (is_mod)
        mod_q <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mod_dk         <= 1'b1;
      mod_dkjr       <= 1'b0;
      mod_dk3        <= 1'b0;
      mod_radarscope <= 1'b0;
      mod_pestplace  <= 1'b0;
      mod_unknown    <= 1'b0;
    end else begin
      mod_dk         <= (mod_q == 8'd0);
      mod_dkjr       <= (mod_q == 8'd1);
      mod_dk3        <= (mod_q == 8'd2);
      mod_radarscope <= (mod_q == 8'd3);
      mod_pestplace  <= (mod_q == 8'd4);
      mod_unknown    <= (mod_q >  8'd4);
    end
  end

endmodule
